pixel_frame_tx: RTL and testbench
=================================

PIXEL_FRAME_TX -- requirements
Module: pixel_frame_tx

Interface
REQ-001 SHALL have parameter: PIXEL_WIDTH, 16, word width of pixel and line data.
REQ-002 SHALL have parameter: NUM_PIXEL, 16, pixels per frame.
REQ-003 SHALL have parameter: FIFO_DEPTH, 32, pixel buffer depth; power of two, >= NUM_PIXEL.
REQ-004 SHALL have port: CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: START  input  1  one-cycle request to send one frame.
REQ-007 SHALL have port: CNTL_WORD  input  PIXEL_WIDTH  control word; sampled at frame launch.
REQ-008 SHALL have port: PIX_VALID  input  1  upstream pixel valid.
REQ-009 SHALL have port: PIX_DATA  input  PIXEL_WIDTH  upstream pixel.
REQ-010 SHALL have port: PIX_READY  output  1  buffer can accept a pixel.
REQ-011 SHALL have port: DOUT  output  PIXEL_WIDTH  line word toward serializer, registered.
REQ-012 SHALL have port: FRAME_ACTIVE  output  1  high while DOUT carries a frame word.
REQ-013 SHALL have port: DONE  output  1  one-cycle pulse after last pixel word.
REQ-014 SHALL have port: LEVEL  output  clog2(FIFO_DEPTH)+1  buffer occupancy.

Function
REQ-015 SHALL push PIX_DATA into buffer on any cycle with PIX_VALID && PIX_READY; PIX_READY = (LEVEL < FIFO_DEPTH).
REQ-016 SHALL allow push and pop in the same cycle; LEVEL unchanged then; no overflow, no underflow.
REQ-017 SHALL latch START into a one-deep pending flag; START while pending set is absorbed (no second queueing).
REQ-018 SHALL use states IDLE, SYNC0, SYNC1, SYNC2, CNTL, PIXEL.
REQ-019 SHALL leave IDLE only when pending && LEVEL >= NUM_PIXEL; launch clears pending and captures CNTL_WORD.
REQ-020 SHALL drive DOUT: IDLE 0x0000, SYNC0 0xFFFF, SYNC1 0xFFFF, SYNC2 0xAAAA, CNTL captured control word, PIXEL popped buffer word.
REQ-021 SHALL emit DOUT=0xFFFF in the cycle after the launch cycle (launch latency 1).
REQ-022 SHALL advance SYNC0->SYNC1->SYNC2->CNTL->PIXEL unconditionally, one cycle each.
REQ-023 SHALL stay in PIXEL exactly NUM_PIXEL cycles, popping one word per cycle in FIFO order, with no gaps.
REQ-024 SHALL return to IDLE after the last pixel and hold IDLE at least one cycle (DOUT=0x0000) before next SYNC0.
REQ-025 SHALL assert DONE for the single cycle the FSM is back in IDLE after a frame.
REQ-026 SHALL drive FRAME_ACTIVE high in SYNC0..PIXEL, low in IDLE.
REQ-027 SHALL keep a pending START set during a frame and relaunch after the mandatory IDLE cycle if LEVEL >= NUM_PIXEL.
REQ-028 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, on RST high (any time, mid-frame included): FSM IDLE, buffer empty, LEVEL 0, pending 0, DOUT 0x0000, FRAME_ACTIVE 0, DONE 0, PIX_READY 1 after release.
REQ-030 SHALL not emit partial frames after reset release; next frame begins with SYNC0.

Configuration
REQ-031 SHALL support macro PIXEL_FRAME_TX_FRAME_CNT_EN.
REQ-032 SHALL, when defined, send in CNTL a 16-bit internal frame counter (reset 0, +1 per completed frame, wraps 0xFFFF->0x0000) and ignore CNTL_WORD.
REQ-033 SHALL, when undefined, send captured CNTL_WORD and contain no counter.

Verification
REQ-034 SHALL cover: push 16 pixels 0x0001..0x0010, START -> DOUT FFFF,FFFF,AAAA,CNTL,0x0001..0x0010, then 0x0000, DONE pulse, 21 cycles total.
REQ-035 SHALL cover: START with LEVEL=10 -> no launch; 6 more pushes -> launch next cycle, pixels in order.
REQ-036 SHALL cover: 32 pushes, START pulsed twice during frame 1 -> exactly two back-to-back frames, one 0x0000 cycle between, LEVEL 0 at end.
REQ-037 SHALL cover: PIX_VALID held high with buffer full -> PIX_READY 0, LEVEL stays 32, no data lost.
REQ-038 SHALL cover: RST asserted during PIXEL cycle 5 -> DOUT 0x0000, LEVEL 0, FRAME_ACTIVE 0 immediately; next frame starts at SYNC0.
REQ-039 SHALL cover: with PIXEL_FRAME_TX_FRAME_CNT_EN, three frames -> CNTL words 0x0000, 0x0001, 0x0002.

Source files
------------

// File: rtl/pixel_frame_tx.sv
// Pixel frame transmitter: buffers upstream pixels, then sends SYNC x3, a control word and NUM_PIXEL pixels.
// Optional: define PIXEL_FRAME_TX_FRAME_CNT_EN to send an internal frame counter in the control slot.
module pixel_frame_tx #(
    parameter int PIXEL_WIDTH = 16,
    parameter int NUM_PIXEL   = 16,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [PIXEL_WIDTH-1:0]        CNTL_WORD,
    input  logic                          PIX_VALID,
    input  logic [PIXEL_WIDTH-1:0]        PIX_DATA,
    output logic                          PIX_READY,
    output logic [PIXEL_WIDTH-1:0]        DOUT,
    output logic                          FRAME_ACTIVE,
    output logic                          DONE,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(NUM_PIXEL + 1);

    localparam logic [LW-1:0]          DEPTH_LVL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]          FRAME_LVL  = LW'(NUM_PIXEL);
    localparam logic [CW-1:0]          LAST_PIX   = CW'(NUM_PIXEL - 1);
    localparam logic [PIXEL_WIDTH-1:0] SYNC_WORD  = PIXEL_WIDTH'(16'hFFFF);
    localparam logic [PIXEL_WIDTH-1:0] SYNC2_WORD = PIXEL_WIDTH'(16'hAAAA);

    typedef enum logic [2:0] {
        IDLE,
        SYNC0,
        SYNC1,
        SYNC2,
        CNTL,
        PIXEL
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [PIXEL_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic                   pending;
    logic [CW-1:0]          pix_cnt;
    logic                   push;
    logic                   pop;
    logic                   launch;
    logic [PIXEL_WIDTH-1:0] cntl_value;
    logic [PIXEL_WIDTH-1:0] dout_next;

    assign PIX_READY = (level < DEPTH_LVL);
    assign LEVEL     = level;
    assign push      = PIX_VALID && PIX_READY;

`ifdef PIXEL_FRAME_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        unused_cntl_word;

    assign unused_cntl_word = ^CNTL_WORD;
    assign cntl_value       = PIXEL_WIDTH'(frame_cnt);

    // Counts completed frames; stable for the whole of the next frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_cnt <= '0;
        end else if (state == PIXEL && next_state == IDLE) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    logic [PIXEL_WIDTH-1:0] cntl_q;

    assign cntl_value = cntl_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cntl_q <= '0;
        end else if (launch) begin
            cntl_q <= CNTL_WORD;
        end
    end
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (pending && level >= FRAME_LVL) begin
                    next_state = SYNC0;
                    launch     = 1'b1;
                end
            end
            SYNC0:   next_state = SYNC1;
            SYNC1:   next_state = SYNC2;
            SYNC2:   next_state = CNTL;
            CNTL:    next_state = PIXEL;
            PIXEL:   if (pix_cnt == LAST_PIX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // DOUT is registered from next_state so the word lines up with the state it belongs to.
    always_comb begin
        dout_next = '0;
        pop       = 1'b0;
        case (next_state)
            SYNC0, SYNC1: dout_next = SYNC_WORD;
            SYNC2:        dout_next = SYNC2_WORD;
            CNTL:         dout_next = cntl_value;
            PIXEL: begin
                dout_next = mem[rd_ptr];
                pop       = 1'b1;
            end
            default:      dout_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            DOUT         <= '0;
            FRAME_ACTIVE <= 1'b0;
            DONE         <= 1'b0;
            pending      <= 1'b0;
            pix_cnt      <= '0;
        end else begin
            state        <= next_state;
            DOUT         <= dout_next;
            FRAME_ACTIVE <= (next_state != IDLE);
            DONE         <= (state == PIXEL) && (next_state == IDLE);
            pending      <= launch ? 1'b0 : (pending | START);
            pix_cnt      <= (state == PIXEL) ? pix_cnt + 1'b1 : '0;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by level and the pointers alone.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= PIX_DATA;
    end

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Self-checking bench for pixel_frame_tx: directed scenarios plus random traffic against a frame-position model.
`timescale 1ns/1ps
module tb_pixel_frame_tx;

    localparam int PW        = 16;
    localparam int NPIX      = 16;
    localparam int DEPTH     = 32;
    localparam int LW        = 6;
    localparam int FRAME_LEN = NPIX + 4;

    typedef logic [PW+LW+2:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] cntl_word = '0;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_ready;
    logic [PW-1:0] dout;
    logic          frame_active;
    logic          done;
    logic [LW-1:0] level;

    pixel_frame_tx #(.PIXEL_WIDTH(PW), .NUM_PIXEL(NPIX), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst), .START(start), .CNTL_WORD(cntl_word),
        .PIX_VALID(pix_valid), .PIX_DATA(pix_data), .PIX_READY(pix_ready),
        .DOUT(dout), .FRAME_ACTIVE(frame_active), .DONE(done), .LEVEL(level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position within the frame (-1 when idle) plus a queue of buffered pixels.
    int          m_pos;
    bit          m_pending;
    int          m_frames;
    logic [15:0] m_cntl;
    logic [15:0] m_dout;
    bit          m_fa;
    bit          m_done;
    logic [15:0] m_q[$];

    task automatic model_reset();
        m_pos = -1; m_pending = 0; m_frames = 0; m_cntl = '0;
        m_dout = '0; m_fa = 0; m_done = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input logic s, input logic v, input logic [15:0] d, input logic [15:0] c);
        int  size_now;
        bit  ready;
        bit  launch_now;
        int  pos_next;
        size_now   = m_q.size();
        ready      = size_now < DEPTH;
        launch_now = (m_pos < 0) && m_pending && (size_now >= NPIX);
        m_done     = (m_pos == FRAME_LEN - 1);
        if (m_done) m_frames++;
        if (launch_now) begin
            pos_next = 0;
`ifdef PIXEL_FRAME_TX_FRAME_CNT_EN
            m_cntl = 16'(m_frames);
`else
            m_cntl = c;
`endif
        end else if (m_pos >= 0) begin
            pos_next = (m_pos == FRAME_LEN - 1) ? -1 : m_pos + 1;
        end else begin
            pos_next = -1;
        end
        if (pos_next < 0)       m_dout = 16'h0000;
        else if (pos_next < 2)  m_dout = 16'hFFFF;
        else if (pos_next == 2) m_dout = 16'hAAAA;
        else if (pos_next == 3) m_dout = m_cntl;
        else                    m_dout = m_q.pop_front();
        if (v && ready) m_q.push_back(d);
        m_pending = launch_now ? 1'b0 : (m_pending | s);
        m_fa      = (pos_next >= 0);
        m_pos     = pos_next;
    endtask

    function automatic vec_t dut_vec();
        return {dout, frame_active, done, level, pix_ready};
    endfunction

    function automatic vec_t model_vec();
        return {m_dout, m_fa, m_done, LW'(m_q.size()), (m_q.size() < DEPTH)};
    endfunction

    task automatic tick(input logic s, input logic v, input logic [15:0] d, input logic [15:0] c);
        start = s; pix_valid = v; pix_data = d; cntl_word = c;
        model_edge(s, v, d, c);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start = 0; pix_valid = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (dout !== 16'h0000) $display("FAIL reset_dout got %h want 0000", dout); else n_pass++;
        n_checks++; if (frame_active !== 1'b0) $display("FAIL reset_frame_active got %b want 0", frame_active); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_checks++; if (level !== 6'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL reset_pix_ready got %b want 1", pix_ready); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [15:0] ctl;
        logic [15:0] exp_seq [FRAME_LEN+1];
        ctl = 16'($urandom);
        for (int i = 0; i < NPIX; i++) begin
            tick(0, 1, 16'(i + 1), ctl);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL single_push %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        exp_seq[0] = 16'hFFFF; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'hAAAA;
`ifdef PIXEL_FRAME_TX_FRAME_CNT_EN
        exp_seq[3] = 16'h0000;
`else
        exp_seq[3] = ctl;
`endif
        for (int i = 0; i < NPIX; i++) exp_seq[4 + i] = 16'(i + 1);
        exp_seq[FRAME_LEN] = 16'h0000;
        tick(1, 0, 16'h0, ctl);
        for (int k = 0; k <= FRAME_LEN; k++) begin
            tick(0, 0, 16'h0, ctl);
            n_checks++; if (dout !== exp_seq[k]) $display("FAIL single_word %0d got %h want %h", k, dout, exp_seq[k]); else n_pass++;
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL single_model %0d got %h want %h", k, dut_vec(), model_vec()); else n_pass++;
        end
        n_checks++; if (done !== 1'b1) $display("FAIL single_done got %b want 1", done); else n_pass++;
    endtask

    task automatic test_partial_level();
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 16'($urandom), 16'h1234);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL partial_push %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        tick(1, 0, 16'h0, 16'h1234);
        for (int i = 0; i < 5; i++) tick(0, 0, 16'h0, 16'h1234);
        n_checks++; if (frame_active !== 1'b0) $display("FAIL partial_no_launch got %b want 0", frame_active); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 16'($urandom), 16'h1234);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL partial_fill %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        tick(0, 0, 16'h0, 16'h1234);
        n_checks++; if (dout !== 16'hFFFF) $display("FAIL partial_launch got %h want ffff", dout); else n_pass++;
        for (int i = 0; i < FRAME_LEN; i++) begin
            tick(0, 0, 16'h0, 16'h1234);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL partial_frame %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        n_done = 0;
        for (int i = 0; i < 2 * NPIX; i++) tick(0, 1, 16'($urandom), 16'h5A5A);
        tick(1, 0, 16'h0, 16'h5A5A);
        for (int i = 0; i < 60; i++) begin
            tick((i == 6) || (i == 12), 0, 16'h0, 16'(i));
            if (done === 1'b1) n_done++;
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL b2b_model %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        n_checks++; if (n_done != 2) $display("FAIL b2b_frames got %0d want 2", n_done); else n_pass++;
        n_checks++; if (level !== 6'd0) $display("FAIL b2b_level got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) tick(0, 1, 16'($urandom), 16'h0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 16'hDEAD, 16'h0);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL full_hold %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        n_checks++; if (pix_ready !== 1'b0) $display("FAIL full_ready got %b want 0", pix_ready); else n_pass++;
        n_checks++; if (level !== 6'd32) $display("FAIL full_level got %0d want 32", level); else n_pass++;
        for (int f = 0; f < 2; f++) begin
            tick(1, 0, 16'h0, 16'h0);
            for (int i = 0; i < FRAME_LEN + 2; i++) begin
                tick(0, 0, 16'h0, 16'h0);
                n_checks++; if (dut_vec() !== model_vec()) $display("FAIL full_drain %0d/%0d got %h want %h", f, i, dut_vec(), model_vec()); else n_pass++;
            end
        end
        n_checks++; if (level !== 6'd0) $display("FAIL full_final_level got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < NPIX; i++) tick(0, 1, 16'($urandom), 16'h0);
        tick(1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 30 && m_pos != 8; i++) begin
            tick(0, 0, 16'h0, 16'h0);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL midrst_pre %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        #2 rst = 1;
        #1;
        n_checks++; if (dout !== 16'h0000) $display("FAIL midrst_dout got %h want 0000", dout); else n_pass++;
        n_checks++; if (level !== 6'd0) $display("FAIL midrst_level got %0d want 0", level); else n_pass++;
        n_checks++; if (frame_active !== 1'b0) $display("FAIL midrst_active got %b want 0", frame_active); else n_pass++;
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 16'h0, 16'h0);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL midrst_quiet %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
        for (int i = 0; i < NPIX; i++) tick(0, 1, 16'($urandom), 16'h0);
        tick(1, 0, 16'h0, 16'h0);
        tick(0, 0, 16'h0, 16'h0);
        n_checks++; if (dout !== 16'hFFFF) $display("FAIL midrst_sync0 got %h want ffff", dout); else n_pass++;
        for (int i = 0; i < FRAME_LEN; i++) begin
            tick(0, 0, 16'h0, 16'h0);
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL midrst_frame %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(15) == 0), ($urandom_range(9) < 6), 16'($urandom), 16'($urandom));
            n_checks++; if (dut_vec() !== model_vec()) $display("FAIL random %0d got %h want %h", i, dut_vec(), model_vec()); else n_pass++;
        end
    endtask

`ifdef PIXEL_FRAME_TX_FRAME_CNT_EN
    task automatic test_frame_cnt();
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) tick(0, 1, 16'($urandom), 16'($urandom));
            tick(1, 0, 16'h0, 16'($urandom));
            for (int k = 0; k <= FRAME_LEN; k++) begin
                tick(0, 0, 16'h0, 16'($urandom));
                if (k == 3) begin
                    n_checks++; if (dout !== 16'(f)) $display("FAIL frame_cnt %0d got %h want %h", f, dout, 16'(f)); else n_pass++;
                end
                n_checks++; if (dut_vec() !== model_vec()) $display("FAIL frame_cnt_model %0d/%0d got %h want %h", f, k, dut_vec(), model_vec()); else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_partial_level();
        test_back_to_back();
        test_full();
        test_reset_mid_frame();
        test_random();
`ifdef PIXEL_FRAME_TX_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
